// File: rtl/decoder_pkg.sv
// Shared definitions for the LED decoder/scanner: mode encodings and the
// default prescaler period.
package decoder_pkg;

    typedef enum logic [1:0] {
        MODE_DECODE    = 2'b00,
        MODE_SCAN_UP   = 2'b01,
        MODE_SCAN_DOWN = 2'b10,
        MODE_HOLD      = 2'b11
    } mode_e;

    localparam int DIV_MAX_DEFAULT = 100_000_000;

    // True for the two modes in which the prescaler advances the position.
    function automatic logic is_scan_mode(input mode_e m);
        logic r;
        case (m)
            MODE_SCAN_UP:   r = 1'b1;
            MODE_SCAN_DOWN: r = 1'b1;
            default:        r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Scan prescaler: counts 0..DIV_MAX-1 while run is high and flags the last
// count as a step tick. clr restarts the period and masks the tick.
module tick_gen
    import decoder_pkg::*;
#(
    parameter int DIV_MAX = DIV_MAX_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clr,
    output logic tick
);

    // Width holds DIV_MAX-1 exactly, including when DIV_MAX is a power of two.
    localparam int CNT_W = $clog2(DIV_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_MAX - 1);

    logic [CNT_W-1:0] div_cnt_r;

    // Tick on the final count of a period; a clear in the same cycle wins.
    always_comb begin
        tick = run & ~clr & (div_cnt_r == CNT_LAST);
    end

    // Prescaler count: clear has priority, otherwise count and wrap while running.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            div_cnt_r <= {CNT_W{1'b0}};
        end else if (run) begin
            if (div_cnt_r == CNT_LAST) begin
                div_cnt_r <= {CNT_W{1'b0}};
            end else begin
                div_cnt_r <= div_cnt_r + CNT_W'(1);
            end
        end else begin
            div_cnt_r <= div_cnt_r;
        end
    end

endmodule

// File: rtl/led_decoder_seq.sv
// One-hot LED driver: decodes a switch index directly, or scans a lit
// position up/down at a prescaled rate, with hold, load and enable control.
module led_decoder_seq
    import decoder_pkg::*;
#(
    parameter int SEL_W   = 2,
    parameter int OUT_W   = 2 ** SEL_W,
    parameter int DIV_MAX = DIV_MAX_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [SEL_W-1:0] sw,
    output logic [OUT_W-1:0] led,
    output logic             wrap,
    output logic             valid
);

    localparam logic [SEL_W-1:0] POS_LAST = SEL_W'(OUT_W - 1);
    localparam logic [SEL_W-1:0] POS_ZERO = {SEL_W{1'b0}};

    mode_e            mode_s;
    mode_e            prev_mode_r;
    logic             mode_chg_s;
    logic             run_s;
    logic             clr_s;
    logic             tick_s;
    logic [SEL_W-1:0] pos_r;
    logic [SEL_W-1:0] pos_next_s;
    logic             wrap_next_s;
    logic [OUT_W-1:0] led_next_s;

    assign mode_s = mode_e'(mode);

    // Prescaler controls: run in scan modes, restart on load or any mode change.
    always_comb begin
        mode_chg_s = (mode_s != prev_mode_r);
        run_s      = en & is_scan_mode(mode_s);
        clr_s      = en & (load | mode_chg_s);
    end

    tick_gen #(
        .DIV_MAX (DIV_MAX)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run_s),
        .clr   (clr_s),
        .tick  (tick_s)
    );

    // Next position and wrap flag; load beats tick, and a load never wraps.
    always_comb begin
        pos_next_s  = pos_r;
        wrap_next_s = 1'b0;
        if (!en) begin
            pos_next_s = pos_r;
        end else if (load) begin
            pos_next_s = sw;
        end else if (mode_s == MODE_DECODE) begin
            pos_next_s = sw;
        end else if (tick_s) begin
            case (mode_s)
                MODE_SCAN_UP: begin
                    pos_next_s  = pos_r + SEL_W'(1);
                    wrap_next_s = (pos_r == POS_LAST);
                end
                MODE_SCAN_DOWN: begin
                    pos_next_s  = pos_r - SEL_W'(1);
                    wrap_next_s = (pos_r == POS_ZERO);
                end
                default: begin
                    pos_next_s = pos_r;
                end
            endcase
        end else begin
            pos_next_s = pos_r;
        end
    end

    // One-hot image of the next position, blanked while disabled.
    always_comb begin
        if (en) begin
            led_next_s = OUT_W'(1) << pos_next_s;
        end else begin
            led_next_s = {OUT_W{1'b0}};
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pos_r       <= {SEL_W{1'b0}};
            prev_mode_r <= MODE_DECODE;
            led         <= {OUT_W{1'b0}};
            wrap        <= 1'b0;
            valid       <= 1'b0;
        end else begin
            pos_r       <= pos_next_s;
            prev_mode_r <= mode_s;
            led         <= led_next_s;
            wrap        <= wrap_next_s;
            valid       <= en;
        end
    end

endmodule

// File: doc/led_decoder_seq.md
LED_DECODER_SEQ -- requirements
Module: led_decoder_seq

Interface
- REQ-001: Parameter SEL_W, default 2, selects the width of the index input; SEL_W SHALL be in the range 1..5.
- REQ-002: Parameter OUT_W, default 2**SEL_W, sets the one-hot output width; it is derived and SHALL NOT be overridden.
- REQ-003: Parameter DIV_MAX, default 100_000_000, sets the scan step period in clk cycles; DIV_MAX SHALL be >= 2.
- REQ-004: Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
- REQ-005: Port rst_n, input, 1 bit: reset, synchronous and active-low.
- REQ-006: Port en, input, 1 bit: block enable.
- REQ-007: Port mode, input, 2 bits: 00 DECODE, 01 SCAN_UP, 10 SCAN_DOWN, 11 HOLD.
- REQ-008: Port load, input, 1 bit: a one-cycle request to load the position from sw.
- REQ-009: Port sw, input, SEL_W bits: index value.
- REQ-010: Port led, output, OUT_W bits: registered one-hot output, or all zeros.
- REQ-011: Port wrap, output, 1 bit: registered one-cycle pulse on a scan wrap-around.
- REQ-012: Port valid, output, 1 bit: registered copy of en.

Function
- REQ-013: Internal state SHALL be pos (SEL_W bits) plus a prescaler count div_cnt (0..DIV_MAX-1).
- REQ-014: In DECODE with en=1, pos SHALL load sw every cycle, so led = onehot(sw) exactly 1 cycle after sw is sampled.
- REQ-015: In SCAN_UP or SCAN_DOWN with en=1, div_cnt SHALL increment each cycle and wrap to 0 after DIV_MAX-1.
- REQ-016: tick SHALL be asserted in the cycle where div_cnt==DIV_MAX-1.
- REQ-017: On tick, pos SHALL step +1 (SCAN_UP) or -1 (SCAN_DOWN), modulo OUT_W.
- REQ-018: In HOLD with en=1, pos SHALL remain unchanged unless load=1.
- REQ-019: load=1 with en=1 SHALL set pos to sw and clear div_cnt in any mode; load SHALL take priority over tick in the same cycle.
- REQ-020: Any change of mode between consecutive cycles SHALL clear div_cnt, so the first step after entering a scan mode occurs DIV_MAX cycles later.
- REQ-021: pos SHALL carry over unchanged across a mode change, except in DECODE, where pos tracks sw.
- REQ-022: Each cycle, led SHALL be set to en ? onehot(pos_next) : 0, where pos_next is the value pos takes at that edge.
- REQ-023: Each cycle, valid SHALL be set to en.
- REQ-024: wrap SHALL pulse for exactly 1 cycle, aligned with led, when a tick steps pos from OUT_W-1 to 0 (up) or from 0 to OUT_W-1 (down).
- REQ-025: A load SHALL never generate wrap.
- REQ-026: With en=0, pos and div_cnt SHALL hold; load and tick SHALL be ignored; led and wrap SHALL be 0.
- REQ-027: When en returns to 1, operation SHALL resume from the held pos and div_cnt.
- REQ-028: led SHALL always be either exactly one-hot or all zeros; no other pattern is permitted.

Reset
- REQ-029: While rst_n=0 at a clk edge, pos, div_cnt, led, wrap and valid SHALL all be set to 0, and the remembered previous mode SHALL be set to DECODE.
- REQ-030: Reset asserted mid-scan SHALL take effect at the next edge; the first edge with rst_n=1 SHALL behave as an ordinary cycle from the reset state.

Structure
- REQ-031: The mode encodings (MODE_DECODE, MODE_SCAN_UP, MODE_SCAN_DOWN, MODE_HOLD) SHALL live in the shared package decoder_pkg, together with the DIV_MAX default.
- REQ-032: The prescaler SHALL be a sub-module tick_gen (parameter DIV_MAX; ports clk, rst_n, run, clr, tick).
- REQ-033: Counter width SHALL be $clog2(DIV_MAX), with no truncation at DIV_MAX = 2**k.

Verification (SEL_W=2, DIV_MAX=4)
- REQ-034: Reset, then en=1, DECODE, sw=0,1,2,3 on consecutive cycles -> led = 0001,0010,0100,1000, each 1 cycle after its sw; valid=1.
- REQ-035: en=1, HOLD, sw=3, load pulse, then SCAN_UP -> led 1000 for 4 cycles, then 0001 with wrap=1 for that single cycle, then 0010 4 cycles later.
- REQ-036: SCAN_DOWN from pos=0 -> after 4 cycles led=1000 with wrap=1; load with sw=2 coinciding with a tick -> led=0100, wrap=0.
- REQ-037: SCAN_UP at pos=1 with div_cnt=2, then en=0 for 10 cycles -> led=0000 and valid=0; after en=1, the step to 0100 occurs 2 cycles later.
- REQ-038: rst_n=0 for 1 cycle mid SCAN_UP at pos=2 -> next cycle led=0000, wrap=0, valid=0; next step occurs 4 cycles after rst_n rises.
- REQ-039: Random stimulus over 10k cycles -> led is one-hot or zero on every cycle, and wrap never asserts outside scan modes.
